// File: rtl/ldm_stm_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ldm_stm_sequencer                                             |
// | Purpose  : Sequences ARM-style LDM/STM block transfers. One memory beat  |
// |            is issued per set bit of the register list, lowest register   |
// |            first at ascending word addresses, followed by an optional    |
// |            base-register writeback and a one-cycle done pulse.           |
// | Ports    : clk, rst (async, active-low)                                  |
// |            start, ir[31:0], base_addr[31:0]  - transfer launch           |
// |            mem_req, mem_we, mem_addr, mem_ack - memory beat handshake    |
// |            reg_idx, reg_latch                 - register-bank access     |
// |            wb_latch, wb_data                  - Rn writeback             |
// |            busy, done                         - status                   |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module ldm_stm_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] ir,
  input  logic [31:0] base_addr,
  input  logic        mem_ack,
  output logic        busy,
  output logic [3:0]  reg_idx,
  output logic [31:0] mem_addr,
  output logic        mem_req,
  output logic        mem_we,
  output logic        reg_latch,
  output logic        wb_latch,
  output logic [31:0] wb_data,
  output logic        done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_WB   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [31:0] c_WORD = 32'd4;

  state_t      r_state;
  logic [15:0] r_mask;      // registers still to be transferred
  logic [31:0] r_addr;      // address of the current beat
  logic [31:0] r_wb_data;   // final Rn value, computed once at launch
  logic [3:0]  r_rn;
  logic        r_load;
  logic        r_wb_en;     // writeback survives the "Rn loaded" override

  // Instruction fields
  logic [15:0] w_list;
  logic        w_p;
  logic        w_u;
  logic        w_w;
  logic        w_l;
  logic [3:0]  w_rn;
  logic        w_unused;

  assign w_list   = ir[15:0];
  assign w_p      = ir[24];
  assign w_u      = ir[23];
  assign w_w      = ir[21];
  assign w_l      = ir[20];
  assign w_rn     = ir[19:16];
  assign w_unused = ^{ir[31:25], ir[22]};

  // Population count of the register list
  logic [4:0] w_count;
  always_comb begin
    w_count = 5'd0;
    for (int i = 0; i < 16; i++) begin
      w_count = w_count + {4'd0, w_list[i]};
    end
  end

  // Byte span of the whole block (4 * n)
  logic [31:0] w_span;
  assign w_span = {25'd0, w_count, 2'b00};

  // Lowest-addressed word of the block; decrementing modes start below base
  // so that registers still ascend in address order.
  logic [31:0] w_first_addr;
  always_comb begin
    w_first_addr = base_addr;
    case ({w_u, w_p})
      2'b10:   w_first_addr = base_addr;
      2'b11:   w_first_addr = base_addr + c_WORD;
      2'b00:   w_first_addr = base_addr - w_span + c_WORD;
      default: w_first_addr = base_addr - w_span;
    endcase
  end

  logic [31:0] w_wb_value;
  assign w_wb_value = w_u ? (base_addr + w_span) : (base_addr - w_span);

  // A load that overwrites Rn wins over the writeback.
  logic w_wb_en;
  assign w_wb_en = w_w & ~(w_l & w_list[w_rn]);

  // Lowest set bit of the remaining mask
  logic [3:0] w_low_idx;
  always_comb begin
    w_low_idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (r_mask[i]) begin
        w_low_idx = 4'(i);
      end
    end
  end

  // Clearing the lowest set bit: x & (x - 1)
  logic [15:0] w_mask_next;
  assign w_mask_next = r_mask & (r_mask - 16'd1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_mask    <= 16'd0;
      r_addr    <= 32'd0;
      r_wb_data <= 32'd0;
      r_rn      <= 4'd0;
      r_load    <= 1'b0;
      r_wb_en   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mask    <= w_list;
            r_addr    <= w_first_addr;
            r_wb_data <= w_wb_value;
            r_rn      <= w_rn;
            r_load    <= w_l;
            r_wb_en   <= w_wb_en;
            r_state   <= (w_list == 16'd0) ? S_DONE : S_XFER;
          end
        end
        S_XFER: begin
          if (mem_ack) begin
            r_mask <= w_mask_next;
            r_addr <= r_addr + c_WORD;
            if (w_mask_next == 16'd0) begin
              r_state <= r_wb_en ? S_WB : S_DONE;
            end
          end
        end
        S_WB: begin
          r_state <= S_DONE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Outputs are decoded directly from state registers, so reset clears them
  // all at once; reg_latch alone qualifies the registered state with mem_ack
  // to mark the accepted load beat in the same cycle.
  assign busy      = (r_state != S_IDLE);
  assign mem_req   = (r_state == S_XFER);
  assign mem_we    = (r_state == S_XFER) & ~r_load;
  assign mem_addr  = (r_state == S_XFER) ? r_addr : 32'd0;
  assign reg_latch = (r_state == S_XFER) & r_load & mem_ack;
  assign wb_latch  = (r_state == S_WB);
  assign wb_data   = (r_state == S_WB) ? r_wb_data : 32'd0;
  assign done      = (r_state == S_DONE);

  always_comb begin
    reg_idx = 4'd0;
    case (r_state)
      S_XFER:  reg_idx = w_low_idx;
      S_WB:    reg_idx = r_rn;
      default: reg_idx = 4'd0;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_ldm_stm_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module   : tb_ldm_stm_sequencer                                          |
// | Purpose  : Directed self-checking bench for ldm_stm_sequencer.           |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_ldm_stm_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        mem_ack = 1'b0;
  logic [31:0] ir = 32'd0;
  logic [31:0] base_addr = 32'd0;
  logic        busy, mem_req, mem_we, reg_latch, wb_latch, done;
  logic [3:0]  reg_idx;
  logic [31:0] mem_addr, wb_data;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  ldm_stm_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .ir        (ir),
    .base_addr (base_addr),
    .mem_ack   (mem_ack),
    .busy      (busy),
    .reg_idx   (reg_idx),
    .mem_addr  (mem_addr),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .reg_latch (reg_latch),
    .wb_latch  (wb_latch),
    .wb_data   (wb_data),
    .done      (done)
  );

  // Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic kick(input logic [31:0] t_ir, input logic [31:0] t_base);
    ir        = t_ir;
    base_addr = t_base;
    start     = 1'b1;
    adv();
    start     = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    n_chk++; if (busy !== 1'b0) $display("FAIL reset_busy got=%0h exp=0", busy); else n_pass++;
    n_chk++; if ({mem_req, mem_we, reg_latch, wb_latch, done} !== 5'd0)
      $display("FAIL reset_strobes got=%b exp=00000", {mem_req, mem_we, reg_latch, wb_latch, done}); else n_pass++;
    n_chk++; if ({reg_idx, mem_addr, wb_data} !== 68'd0)
      $display("FAIL reset_data got=%h exp=0", {reg_idx, mem_addr, wb_data}); else n_pass++;
    adv();
    rst = 1'b1;
    adv();
  endtask

  // STM r0..r3, increment-after, ack every cycle
  task automatic test_stm_ia();
    mem_ack = 1'b1;
    kick(32'h0080_000F, 32'h0000_1000);
    for (int i = 0; i < 4; i++) begin
      mid();
      n_chk++; if (mem_req !== 1'b1) $display("FAIL stm_req[%0d] got=%0h exp=1", i, mem_req); else n_pass++;
      n_chk++; if (reg_idx !== 4'(i)) $display("FAIL stm_idx[%0d] got=%0d exp=%0d", i, reg_idx, i); else n_pass++;
      n_chk++; if (mem_addr !== 32'h1000 + 32'(4 * i)) $display("FAIL stm_addr[%0d] got=%h exp=%h", i, mem_addr, 32'h1000 + 32'(4 * i)); else n_pass++;
      n_chk++; if ({mem_we, reg_latch, wb_latch} !== 3'b100) $display("FAIL stm_we_latch[%0d] got=%b exp=100", i, {mem_we, reg_latch, wb_latch}); else n_pass++;
      adv();
    end
    mid();
    n_chk++; if ({done, busy, wb_latch, mem_req} !== 4'b1100) $display("FAIL stm_done got=%b exp=1100", {done, busy, wb_latch, mem_req}); else n_pass++;
    adv();
    mid();
    n_chk++; if ({done, busy} !== 2'b00) $display("FAIL stm_idle got=%b exp=00", {done, busy}); else n_pass++;
    mem_ack = 1'b0;
    adv();
  endtask

  // LDM pre-decrement with writeback: r0, r4, r15 below 0x2000
  task automatic test_ldm_db_wb();
    logic [3:0]  e_idx [3];
    logic [31:0] e_addr [3];
    e_idx  = '{4'd0, 4'd4, 4'd15};
    e_addr = '{32'h1FF4, 32'h1FF8, 32'h1FFC};
    mem_ack = 1'b1;
    kick(32'h013D_8011, 32'h0000_2000);
    for (int i = 0; i < 3; i++) begin
      mid();
      n_chk++; if (reg_idx !== e_idx[i]) $display("FAIL ldm_idx[%0d] got=%0d exp=%0d", i, reg_idx, e_idx[i]); else n_pass++;
      n_chk++; if (mem_addr !== e_addr[i]) $display("FAIL ldm_addr[%0d] got=%h exp=%h", i, mem_addr, e_addr[i]); else n_pass++;
      n_chk++; if ({mem_req, mem_we, reg_latch} !== 3'b101) $display("FAIL ldm_req_we_latch[%0d] got=%b exp=101", i, {mem_req, mem_we, reg_latch}); else n_pass++;
      adv();
    end
    mid();
    n_chk++; if ({wb_latch, mem_req, reg_latch, done} !== 4'b1000) $display("FAIL ldm_wb_strobes got=%b exp=1000", {wb_latch, mem_req, reg_latch, done}); else n_pass++;
    n_chk++; if (reg_idx !== 4'd13) $display("FAIL ldm_wb_idx got=%0d exp=13", reg_idx); else n_pass++;
    n_chk++; if (wb_data !== 32'h1FF4) $display("FAIL ldm_wb_data got=%h exp=00001ff4", wb_data); else n_pass++;
    adv();
    mid();
    n_chk++; if ({done, wb_latch} !== 2'b10) $display("FAIL ldm_done got=%b exp=10", {done, wb_latch}); else n_pass++;
    adv();
    mem_ack = 1'b0;
  endtask

  // LDM loading Rn itself suppresses the writeback
  task automatic test_ldm_rn_in_list();
    mem_ack = 1'b1;
    kick(32'h00B2_0006, 32'h0000_3000);
    for (int i = 0; i < 2; i++) begin
      mid();
      n_chk++; if (reg_idx !== 4'(i + 1)) $display("FAIL rnlist_idx[%0d] got=%0d exp=%0d", i, reg_idx, i + 1); else n_pass++;
      n_chk++; if (mem_addr !== 32'h3000 + 32'(4 * i)) $display("FAIL rnlist_addr[%0d] got=%h exp=%h", i, mem_addr, 32'h3000 + 32'(4 * i)); else n_pass++;
      n_chk++; if ({reg_latch, wb_latch} !== 2'b10) $display("FAIL rnlist_latch[%0d] got=%b exp=10", i, {reg_latch, wb_latch}); else n_pass++;
      adv();
    end
    mid();
    n_chk++; if ({done, wb_latch} !== 2'b10) $display("FAIL rnlist_done got=%b exp=10", {done, wb_latch}); else n_pass++;
    adv();
    mid();
    n_chk++; if ({busy, wb_latch} !== 2'b00) $display("FAIL rnlist_idle got=%b exp=00", {busy, wb_latch}); else n_pass++;
    mem_ack = 1'b0;
    adv();
  endtask

  // Empty list with W=1: no beats, no writeback, done in the cycle after start
  task automatic test_empty_list();
    kick(32'h00A1_0000, 32'h0000_4000);
    mid();
    n_chk++; if ({done, busy, mem_req, wb_latch} !== 4'b1100) $display("FAIL empty_done got=%b exp=1100", {done, busy, mem_req, wb_latch}); else n_pass++;
    adv();
    mid();
    n_chk++; if ({done, busy, mem_req} !== 3'b000) $display("FAIL empty_idle got=%b exp=000", {done, busy, mem_req}); else n_pass++;
    adv();
  endtask

  // STM decrement-after with 3-cycle ack stalls and a stray start mid-transfer
  task automatic test_stall_and_restart();
    logic [31:0] e_addr [2];
    e_addr = '{32'h0000_000C, 32'h0000_0010};
    kick(32'h0025_0003, 32'h0000_0010);
    for (int b = 0; b < 2; b++) begin
      for (int s = 0; s < 4; s++) begin
        mem_ack = (s == 3);
        start   = (s == 1);
        if (s == 1) begin
          ir        = 32'h0080_FFFF;
          base_addr = 32'hDEAD_0000;
        end
        mid();
        n_chk++; if ({mem_req, mem_we} !== 2'b11) $display("FAIL stall_req[%0d.%0d] got=%b exp=11", b, s, {mem_req, mem_we}); else n_pass++;
        n_chk++; if (mem_addr !== e_addr[b]) $display("FAIL stall_addr[%0d.%0d] got=%h exp=%h", b, s, mem_addr, e_addr[b]); else n_pass++;
        n_chk++; if (reg_idx !== 4'(b)) $display("FAIL stall_idx[%0d.%0d] got=%0d exp=%0d", b, s, reg_idx, b); else n_pass++;
        adv();
      end
    end
    start   = 1'b0;
    mem_ack = 1'b0;
    mid();
    n_chk++; if ({wb_latch, reg_idx} !== {1'b1, 4'd5}) $display("FAIL stall_wb got=%b exp=10101", {wb_latch, reg_idx}); else n_pass++;
    n_chk++; if (wb_data !== 32'h0000_0008) $display("FAIL stall_wb_data got=%h exp=00000008", wb_data); else n_pass++;
    adv();
    mid();
    n_chk++; if (done !== 1'b1) $display("FAIL stall_done got=%0h exp=1", done); else n_pass++;
    adv();
    adv();
    mid();
    n_chk++; if ({busy, mem_req} !== 2'b00) $display("FAIL stall_no_queue got=%b exp=00", {busy, mem_req}); else n_pass++;
    adv();
  endtask

  // Pre-decrement from a low base wraps the address through zero
  task automatic test_wrap();
    mem_ack = 1'b1;
    kick(32'h0120_0003, 32'h0000_0004);
    mid();
    n_chk++; if (mem_addr !== 32'hFFFF_FFFC) $display("FAIL wrap_addr0 got=%h exp=fffffffc", mem_addr); else n_pass++;
    adv();
    mid();
    n_chk++; if (mem_addr !== 32'h0000_0000) $display("FAIL wrap_addr1 got=%h exp=00000000", mem_addr); else n_pass++;
    adv();
    mid();
    n_chk++; if (wb_data !== 32'hFFFF_FFFC) $display("FAIL wrap_wb_data got=%h exp=fffffffc", wb_data); else n_pass++;
    adv();
    adv();
    mem_ack = 1'b0;
    adv();
  endtask

  // Reset during the second beat aborts; a fresh transfer then runs cleanly
  task automatic test_reset_mid_transfer();
    mem_ack = 1'b1;
    kick(32'h0080_000F, 32'h0000_1000);
    mid();
    adv();
    mid();
    n_chk++; if (reg_idx !== 4'd1) $display("FAIL rstmid_second_beat got=%0d exp=1", reg_idx); else n_pass++;
    #2 rst = 1'b0;
    #1;
    n_chk++; if ({busy, mem_req, mem_we, reg_latch, wb_latch, done} !== 6'd0)
      $display("FAIL rstmid_strobes got=%b exp=000000", {busy, mem_req, mem_we, reg_latch, wb_latch, done}); else n_pass++;
    n_chk++; if ({reg_idx, mem_addr, wb_data} !== 68'd0) $display("FAIL rstmid_data got=%h exp=0", {reg_idx, mem_addr, wb_data}); else n_pass++;
    adv();
    n_chk++; if ({busy, mem_req} !== 2'b00) $display("FAIL rstmid_held got=%b exp=00", {busy, mem_req}); else n_pass++;
    rst = 1'b1;
    adv();
    kick(32'h0090_0001, 32'h0000_0500);
    mid();
    n_chk++; if ({mem_req, reg_latch, reg_idx} !== {2'b11, 4'd0}) $display("FAIL rstmid_new_beat got=%b exp=110000", {mem_req, reg_latch, reg_idx}); else n_pass++;
    n_chk++; if (mem_addr !== 32'h0000_0500) $display("FAIL rstmid_new_addr got=%h exp=00000500", mem_addr); else n_pass++;
    adv();
    mid();
    n_chk++; if ({done, wb_latch} !== 2'b10) $display("FAIL rstmid_new_done got=%b exp=10", {done, wb_latch}); else n_pass++;
    adv();
    mem_ack = 1'b0;
    adv();
  endtask

  initial begin
    test_reset();
    test_stm_ia();
    test_ldm_db_wb();
    test_ldm_rn_in_list();
    test_empty_list();
    test_stall_and_restart();
    test_wrap();
    test_reset_mid_transfer();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ldm_stm_sequencer.md
LDM_STM_SEQUENCER -- requirements
Module: ldm_stm_sequencer

Interface
REQ-001 SHALL have one clock and one reset; reset is asynchronous, active-low.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst  in  1  asynchronous active-low reset.
REQ-004 start  in  1  begin block transfer; sampled only in IDLE.
REQ-005 ir  in  32  block-transfer instruction: [24]=P, [23]=U, [21]=W, [20]=L, [19:16]=Rn, [15:0]=register list.
REQ-006 base_addr  in  32  current Rn value, sampled with start.
REQ-007 mem_ack  in  1  memory completed current beat.
REQ-008 busy  out  1  high in every state except IDLE.
REQ-009 reg_idx  out  4  register-bank index for current beat or writeback.
REQ-010 mem_addr  out  32  word address of current beat.
REQ-011 mem_req  out  1  beat request; held until mem_ack.
REQ-012 mem_we  out  1  1=store (L=0), valid while mem_req.
REQ-013 reg_latch  out  1  one-cycle register-bank write strobe for a load beat.
REQ-014 wb_latch  out  1  one-cycle Rn writeback strobe.
REQ-015 wb_data  out  32  Rn writeback value.
REQ-016 done  out  1  one-cycle completion pulse.

Function
REQ-017 States SHALL be IDLE, XFER, WB, DONE.
REQ-018 IDLE, start=1: latch list, P/U/W/L, Rn, base_addr; n = popcount(list); go XFER (n>0) or DONE (n=0).
REQ-019 First address SHALL be: U=1,P=0: base; U=1,P=1: base+4; U=0,P=0: base-4n+4; U=0,P=1: base-4n (mod 2^32).
REQ-020 Registers SHALL transfer lowest index first at ascending addresses, +4 per beat.
REQ-021 XFER: mem_req=1, reg_idx = lowest set bit of remaining mask, mem_addr = current address; first mem_req in cycle after start.
REQ-022 mem_ack in XFER: clear that bit, address += 4, reg_latch=1 same cycle if L=1; mem_ack outside XFER ignored.
REQ-023 mem_ack on last bit: next state WB if W=1 and not (L=1 and Rn in list), else DONE.
REQ-024 WB: wb_latch=1, reg_idx=Rn, wb_data = U ? base+4n : base-4n; next DONE.
REQ-025 DONE: done=1 for one cycle, next IDLE; busy deasserts the cycle IDLE is entered.
REQ-026 start while busy SHALL be ignored; no queuing.
REQ-027 mem_req, reg_latch, wb_latch, done SHALL never assert in IDLE.
REQ-028 Empty list: no beats, no writeback, done two cycles after start.
REQ-029 Address arithmetic SHALL wrap modulo 2^32 with no flag.

Reset
REQ-030 rst=0 SHALL force IDLE immediately; all outputs 0; internal mask/address cleared.
REQ-031 rst asserted mid-transfer SHALL abort with no further strobes; first start after release behaves as from cold reset.

Verification
REQ-032 STM, ir list=0x000F, P=0,U=1,W=0, base=0x1000, ack every cycle -> beats r0..r3 at 0x1000/04/08/0C, mem_we=1, no wb_latch, done at cycle 6.
REQ-033 LDM, list=0x8011, P=1,U=0,W=1,Rn=13, base=0x2000 -> r0@0x1FF4, r4@0x1FF8, r15@0x1FFC, three reg_latch, wb_data=0x1FF4.
REQ-034 LDM, Rn=2, list=0x0006, W=1 -> two reg_latch, wb_latch never asserts.
REQ-035 list=0x0000 -> no mem_req, done pulse cycle 2 after start, busy low after.
REQ-036 mem_ack delayed 3 cycles per beat, start pulsed mid-transfer -> mem_req/addr held stable, extra start ignored.
REQ-037 rst=0 during second beat -> all outputs 0 immediately; new start afterwards completes normally.
